btn_debounce: RTL and testbench

//   Front-end conditioning for raw push-button inputs from the board pins.
//   Per channel: 2-FF synchronises the asynchronous button level, debounces it,
//   and emits a clean level plus one-cycle rise/fall pulses.

---
 rtl/btn_debounce_if.sv | 9 +
 rtl/btn_debounce.sv | 55 +++++
 tb/tb_btn_debounce.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/btn_debounce_if.sv
// btn_debounce_if: raw button levels in, debounced level and edge pulses out.
interface btn_debounce_if #(parameter int N = 2);
  logic [N-1:0] btn;
  logic [N-1:0] btn_db;
  logic [N-1:0] btn_rise;
  logic [N-1:0] btn_fall;
  modport master (output btn, input btn_db, btn_rise, btn_fall);
  modport slave (input btn, output btn_db, btn_rise, btn_fall);
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: per-channel 2-FF synchroniser, counting debouncer and registered rise/fall pulses.
module btn_debounce #(
  parameter int N_BTN = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input logic clk,
  input logic rst_n,
  btn_debounce_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [0:0] STABLE = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;
  logic [N_BTN-1:0] s1, s2, st, db, rise, fall;
  logic [CW-1:0] cnt [N_BTN];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      st <= '0;
      db <= '0;
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      s1 <= bus.btn;
      s2 <= s1;
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        if (st[i] == STABLE) begin
          if (s2[i] != db[i]) begin
            st[i] <= PENDING;
            cnt[i] <= CW'(1);
          end
        end else if (s2[i] == db[i]) begin
          st[i] <= STABLE;
          cnt[i] <= '0;
        end else if (cnt[i] < LAST) begin
          cnt[i] <= cnt[i] + CW'(1);
        end else begin
          // input held away from btn_db long enough: commit the new level
          st[i] <= STABLE;
          cnt[i] <= '0;
          db[i] <= s2[i];
          rise[i] <= s2[i];
          fall[i] <= ~s2[i];
        end
      end
    end
  end
  assign bus.btn_db = db;
  assign bus.btn_rise = rise;
  assign bus.btn_fall = fall;
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: scenario tasks plus randomized traffic checked against a history-based model.
module tb_btn_debounce;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  btn_debounce_if #(.N(2)) bus ();
  btn_debounce #(.N_BTN(2), .DEBOUNCE_CYCLES(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  // Model: keep every value the debouncer observes (btn delayed two edges);
  // a channel flips when its last D observations, all taken since its previous flip, differ from btn_db.
  logic [1:0] p1, p2, m_db, m_rise, m_fall;
  logic [1:0] hist[$];
  int last_flip[2];
  int n;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1 = '0;
      p2 = '0;
      m_db = '0;
      m_rise = '0;
      m_fall = '0;
      hist.delete();
      last_flip[0] = -1;
      last_flip[1] = -1;
      n = 0;
    end else begin
      hist.push_back(p2);
      p2 = p1;
      p1 = bus.btn;
      m_rise = '0;
      m_fall = '0;
      for (int ch = 0; ch < 2; ch++) begin
        bit ok;
        ok = 1'b1;
        for (int j = 0; j < D; j++) begin
          int idx;
          idx = n - j;
          if (idx < 0 || idx <= last_flip[ch]) ok = 1'b0;
          else if (hist[idx][ch] == m_db[ch]) ok = 1'b0;
        end
        if (ok) begin
          m_db[ch] = ~m_db[ch];
          m_rise[ch] = m_db[ch];
          m_fall[ch] = ~m_db[ch];
          last_flip[ch] = n;
        end
      end
      n++;
    end
  end
  // Per-run observations, measured in edges since the last clear().
  int kk, mm, mm_k, both;
  int fr[2], ff[2], nr[2], nf[2];
  logic [5:0] mm_dut, mm_exp;
  logic [1:0] hi;
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic clear();
    kk = 0; mm = 0; mm_k = -1; both = 0; hi = '0;
    mm_dut = '0; mm_exp = '0;
    for (int c = 0; c < 2; c++) begin
      fr[c] = -1; ff[c] = -1; nr[c] = 0; nf[c] = 0;
    end
  endtask
  task automatic run(input int cyc);
    for (int k = 0; k < cyc; k++) begin
      tick();
      if ({bus.btn_db, bus.btn_rise, bus.btn_fall} !== {m_db, m_rise, m_fall}) begin
        if (mm == 0) begin
          mm_k = kk;
          mm_dut = {bus.btn_db, bus.btn_rise, bus.btn_fall};
          mm_exp = {m_db, m_rise, m_fall};
        end
        mm++;
      end
      for (int c = 0; c < 2; c++) begin
        if (bus.btn_rise[c] === 1'b1) begin nr[c]++; if (fr[c] < 0) fr[c] = kk; end
        if (bus.btn_fall[c] === 1'b1) begin nf[c]++; if (ff[c] < 0) ff[c] = kk; end
      end
      if ((bus.btn_rise & bus.btn_fall) !== 2'b00) both++;
      hi = hi | bus.btn_db;
      kk++;
    end
  endtask
  task automatic test_reset();
    bus.btn = 2'b11;
    rst_n = 1'b0;
    repeat (3) tick();
    total++;
    if ({bus.btn_db, bus.btn_rise, bus.btn_fall} !== 6'b0) begin
      bad++; $display("FAIL reset_hold got=%b want=000000", {bus.btn_db, bus.btn_rise, bus.btn_fall});
    end
    rst_n = 1'b1;
    clear();
    run(10);
    total++;
    if (mm !== 0) begin bad++; $display("FAIL reset_model k=%0d got=%b want=%b", mm_k, mm_dut, mm_exp); end
    total++;
    if (fr[0] !== 5 || fr[1] !== 5) begin bad++; $display("FAIL reset_rise_edge got=%0d,%0d want=5,5", fr[0], fr[1]); end
    total++;
    if (nr[0] !== 1 || nr[1] !== 1 || bus.btn_db !== 2'b11) begin
      bad++; $display("FAIL reset_rise_count got=%0d,%0d db=%b want=1,1 db=11", nr[0], nr[1], bus.btn_db);
    end
  endtask
  task automatic test_press();
    bus.btn = 2'b00;
    run(10);
    clear();
    bus.btn = 2'b01;
    run(10);
    total++;
    if (fr[0] !== 5 || nr[0] !== 1) begin bad++; $display("FAIL press_rise got edge=%0d n=%0d want edge=5 n=1", fr[0], nr[0]); end
    total++;
    if (hi[1] !== 1'b0 || nr[1] !== 0 || nf[1] !== 0) begin
      bad++; $display("FAIL press_ch1_quiet got hi=%b r=%0d f=%0d want 0,0,0", hi[1], nr[1], nf[1]);
    end
    clear();
    bus.btn = 2'b00;
    run(10);
    total++;
    if (ff[0] !== 5 || nf[0] !== 1 || nr[0] !== 0) begin
      bad++; $display("FAIL press_fall got edge=%0d n=%0d r=%0d want 5,1,0", ff[0], nf[0], nr[0]);
    end
    total++;
    if (mm !== 0) begin bad++; $display("FAIL press_model k=%0d got=%b want=%b", mm_k, mm_dut, mm_exp); end
  endtask
  task automatic test_bounce();
    clear();
    for (int s = 0; s < 10; s++) begin
      bus.btn = {1'b0, (s % 2) == 0};
      run(2);
    end
    total++;
    if (hi[0] !== 1'b0 || nr[0] !== 0) begin bad++; $display("FAIL bounce_stays_low got hi=%b r=%0d want 0,0", hi[0], nr[0]); end
    bus.btn = 2'b01;
    run(10);
    total++;
    if (fr[0] !== 25 || nr[0] !== 1) begin bad++; $display("FAIL bounce_rise got edge=%0d n=%0d want 25,1", fr[0], nr[0]); end
    total++;
    if (mm !== 0) begin bad++; $display("FAIL bounce_model k=%0d got=%b want=%b", mm_k, mm_dut, mm_exp); end
    bus.btn = 2'b00;
    run(10);
  endtask
  task automatic test_glitch();
    clear();
    bus.btn = 2'b10;
    run(3);
    bus.btn = 2'b00;
    run(10);
    total++;
    if (hi[1] !== 1'b0 || nr[1] !== 0 || nf[1] !== 0) begin
      bad++; $display("FAIL glitch_rejected got hi=%b r=%0d f=%0d want 0,0,0", hi[1], nr[1], nf[1]);
    end
    total++;
    if (mm !== 0) begin bad++; $display("FAIL glitch_model k=%0d got=%b want=%b", mm_k, mm_dut, mm_exp); end
  endtask
  task automatic test_simultaneous();
    clear();
    bus.btn = 2'b11;
    run(10);
    total++;
    if (fr[0] !== 5 || fr[1] !== 5) begin bad++; $display("FAIL simul_rise got=%0d,%0d want=5,5", fr[0], fr[1]); end
    clear();
    bus.btn = 2'b10;
    run(2);
    bus.btn = 2'b00;
    run(10);
    total++;
    if (ff[0] !== 5 || ff[1] !== 7) begin bad++; $display("FAIL simul_fall got=%0d,%0d want=5,7", ff[0], ff[1]); end
    total++;
    if (mm !== 0 || both !== 0) begin bad++; $display("FAIL simul_model k=%0d both=%0d got=%b want=%b", mm_k, both, mm_dut, mm_exp); end
  endtask
  task automatic test_reset_mid();
    bus.btn = 2'b10;
    run(10);
    clear();
    bus.btn = 2'b11;
    run(4);
    total++;
    if (hi !== 2'b10) begin bad++; $display("FAIL midrst_pending got hi=%b want=10", hi); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.btn_db, bus.btn_rise, bus.btn_fall} !== 6'b0) begin
      bad++; $display("FAIL midrst_async got=%b want=000000", {bus.btn_db, bus.btn_rise, bus.btn_fall});
    end
    tick();
    total++;
    if ({bus.btn_db, bus.btn_rise, bus.btn_fall} !== 6'b0) begin
      bad++; $display("FAIL midrst_held got=%b want=000000", {bus.btn_db, bus.btn_rise, bus.btn_fall});
    end
    rst_n = 1'b1;
    clear();
    run(10);
    total++;
    if (fr[0] !== 5 || fr[1] !== 5 || nr[0] !== 1) begin
      bad++; $display("FAIL midrst_fresh_rise got=%0d,%0d n=%0d want=5,5 n=1", fr[0], fr[1], nr[0]);
    end
    total++;
    if (mm !== 0) begin bad++; $display("FAIL midrst_model k=%0d got=%b want=%b", mm_k, mm_dut, mm_exp); end
  endtask
  task automatic test_random();
    clear();
    for (int s = 0; s < 80; s++) begin
      bus.btn = 2'($urandom);
      run($urandom_range(1, 7));
    end
    run(10);
    total++;
    if (mm !== 0) begin bad++; $display("FAIL random_model k=%0d got=%b want=%b", mm_k, mm_dut, mm_exp); end
    total++;
    if (both !== 0) begin bad++; $display("FAIL random_rise_and_fall got=%0d want=0", both); end
  endtask
  initial begin
    bus.btn = 2'b00;
    test_reset();
    test_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
